// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg : shared constants and types for the seven-segment scan logic
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Counter width that stays at least one bit for a modulus of 1
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_timer.sv
// ----------------------------------------------------------------------------
// scan_timer : modulo-REFRESH_DIV slot counter with blank/slot end flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scan_timer
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_blank_done,
  output logic o_slot_done
);

  localparam int CNT_W = cnt_width(REFRESH_DIV);
  localparam logic [CNT_W-1:0] c_LAST_SLOT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] c_LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_blank_done = (r_cnt == c_LAST_BLANK);
  assign o_slot_done  = (r_cnt == c_LAST_SLOT);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (o_slot_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl : 8-digit time-multiplexed scan with guard blanking,
//                     per-digit enable/blink masks and a frame tick
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [SEL_W-1:0]      select,
  output logic                  an_off,
  output logic                  frame_tick,
  output logic                  blink_phase
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_BLANK = 2'(BLANK);
  localparam logic [1:0] ST_SHOW  = 2'(SHOW);

  localparam int BLINK_W = cnt_width(BLINK_FRAMES);
  localparam logic [BLINK_W-1:0] c_LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [SEL_W-1:0]   c_LAST_SEL   = SEL_W'(NUM_DIGITS - 1);

  logic [1:0]         r_state;
  logic [SEL_W-1:0]   r_select;
  logic               r_an_off;
  logic               r_frame_tick;
  logic               r_blink_phase;
  logic [BLINK_W-1:0] r_blink_cnt;

  logic               w_blank_done;
  logic               w_slot_done;
  logic               w_timer_clear;
  logic [1:0]         w_next_state;
  logic [SEL_W-1:0]   w_next_select;
  logic               w_frame_wrap;
  logic               w_next_phase;
  logic [BLINK_W-1:0] w_next_bcnt;
  logic               w_show_lit;
  logic               w_next_an_off;

  // The slot counter only runs while scanning; IDLE holds it at 0
  assign w_timer_clear = ~en | (r_state == ST_IDLE);

  scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clear      (w_timer_clear),
    .o_blank_done (w_blank_done),
    .o_slot_done  (w_slot_done)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_select = r_select;
    w_frame_wrap  = 1'b0;
    case (r_state)
      ST_IDLE:  w_next_state = ST_BLANK;
      ST_BLANK: if (w_blank_done) w_next_state = ST_SHOW;
      ST_SHOW: begin
        if (w_slot_done) begin
          w_next_state  = ST_BLANK;
          w_next_select = (r_select == c_LAST_SEL) ? '0 : r_select + SEL_W'(1);
          w_frame_wrap  = (r_select == c_LAST_SEL);
        end
      end
      default:  w_next_state = ST_IDLE;
    endcase
    if (!en) begin
      w_next_state  = ST_IDLE;
      w_next_select = '0;
      w_frame_wrap  = 1'b0;
    end
  end

  // Blink phase flips together with the frame tick, so slot 0 SHOW sees it
  always_comb begin
    w_next_phase = r_blink_phase;
    w_next_bcnt  = r_blink_cnt;
    if (!en) begin
      w_next_phase = 1'b0;
      w_next_bcnt  = '0;
    end else if (w_frame_wrap) begin
      if (r_blink_cnt == c_LAST_BLINK) begin
        w_next_bcnt  = '0;
        w_next_phase = ~r_blink_phase;
      end else begin
        w_next_bcnt  = r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Entering SHOW never changes select, so the current index is the one lit
  assign w_show_lit    = digit_en[r_select] & ~(blink_mask[r_select] & w_next_phase);
  assign w_next_an_off = (w_next_state == ST_SHOW) ? ~w_show_lit : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_select      <= '0;
      r_an_off      <= 1'b1;
      r_frame_tick  <= 1'b0;
      r_blink_phase <= 1'b0;
      r_blink_cnt   <= '0;
    end else begin
      r_state       <= w_next_state;
      r_select      <= w_next_select;
      r_an_off      <= w_next_an_off;
      r_frame_tick  <= w_frame_wrap;
      r_blink_phase <= w_next_phase;
      r_blink_cnt   <= w_next_bcnt;
    end
  end

  assign select      = r_select;
  assign an_off      = r_an_off;
  assign frame_tick  = r_frame_tick;
  assign blink_phase = r_blink_phase;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_display_scan_ctrl : randomized self-checking bench with a timeline model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_ctrl;

  localparam int RDIV  = 10;
  localparam int BLNK  = 2;
  localparam int BFRM  = 2;
  localparam int FRAME = 8 * RDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] digit_en   = 8'hFF;
  logic [7:0] blink_mask = 8'h00;
  logic [2:0] select;
  logic       an_off;
  logic       frame_tick;
  logic       blink_phase;

  int n_checks = 0;
  int n_errors = 0;

  // Model: time t counted from the first BLANK cycle of slot 0
  bit m_active = 1'b0;
  int m_t      = 0;
  logic [2:0] prev_sel = 3'd0;

  display_scan_ctrl #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLNK),
    .BLINK_FRAMES (BFRM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digit_en    (digit_en),
    .blink_mask  (blink_mask),
    .select      (select),
    .an_off      (an_off),
    .frame_tick  (frame_tick),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got %0d expected %0d", tag, m_t, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] de, input logic [7:0] bm);
    int  e_sel, e_an, e_tick, e_ph, pos;
    rst = r; en = e; digit_en = de; blink_mask = bm;
    @(posedge clk);
    if (r || !e) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
    end else begin
      m_t++;
    end
    #1;
    if (m_active) begin
      e_sel  = (m_t / RDIV) % 8;
      pos    = m_t % RDIV;
      e_ph   = ((m_t / FRAME) / BFRM) % 2;
      e_tick = (m_t > 0 && (m_t % FRAME) == 0) ? 1 : 0;
      if (pos < BLNK) e_an = 1;
      else            e_an = (de[e_sel] && !(bm[e_sel] && e_ph == 1)) ? 0 : 1;
    end else begin
      e_sel = 0; e_an = 1; e_tick = 0; e_ph = 0;
    end
    check("select",      int'(select),      e_sel);
    check("an_off",      int'(an_off),      e_an);
    check("frame_tick",  int'(frame_tick),  e_tick);
    check("blink_phase", int'(blink_phase), e_ph);
    if (select !== prev_sel) check("ghost_an_off", int'(an_off), 1);
    prev_sel = select;
  endtask

  task automatic run(input int n, input logic [7:0] de, input logic [7:0] bm);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, de, bm);
  endtask

  initial begin
    logic [7:0] rde, rbm;
    bit         rr, re;
    // Reset state
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    step(1'b1, 1'b1, 8'hFF, 8'h00);
    // Basic scan over more than two frames
    run(200, 8'hFF, 8'h00);
    // Disabled digit 0
    step(1'b1, 1'b1, 8'hFE, 8'h00);
    run(170, 8'hFE, 8'h00);
    // Blink digit 7 across several half-periods
    step(1'b1, 1'b1, 8'hFF, 8'h80);
    run(340, 8'hFF, 8'h80);
    // Enable dropped during select 3 SHOW, then reasserted
    step(1'b1, 1'b1, 8'hFF, 8'h00);
    run(36, 8'hFF, 8'h00);
    step(1'b0, 1'b0, 8'hFF, 8'h00);
    run(30, 8'hFF, 8'h00);
    // Reset mid-slot during select 5 with enable held
    step(1'b1, 1'b1, 8'hFF, 8'h00);
    run(55, 8'hFF, 8'h00);
    step(1'b1, 1'b1, 8'hFF, 8'h00);
    run(30, 8'hFF, 8'h00);
    // Randomized masks, enable drops and resets
    rde = 8'hFF; rbm = 8'h00;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) rde = 8'($urandom);
      if ($urandom_range(0, 39) == 0) rbm = 8'($urandom);
      rr = ($urandom_range(0, 499) == 0);
      re = ($urandom_range(0, 199) != 0);
      step(rr, re, rde, rbm);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
